egg_timer_ctrl: RTL and testbench

- Sequencing controller for the egg-timer BCD countdown datapath.
- Turns two user buttons and an 8-bit switch bank into the datapath's 3-bit `state` code and 16-bit BCD `timer` preset.
- Generates the 1 Hz decrement strobe from `clkIn`.
- Monitors the four returned digits to detect 00:00 and drives the alarm output.

---
 rtl/egg_timer_ctrl_if.sv | 25 ++
 rtl/egg_timer_ctrl.sv | 150 +++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/egg_timer_ctrl_if.sv
// Bus between the egg-timer sequencing controller and its panel/datapath.
// master = controller side, slave = buttons/switches/datapath side.
interface egg_timer_ctrl_if;
    logic        btn_set;
    logic        btn_start;
    logic [7:0]  sw;
    logic [3:0]  sec_1;
    logic [3:0]  sec_10;
    logic [3:0]  min_1;
    logic [3:0]  min_10;
    logic [2:0]  state;
    logic [15:0] timer;
    logic        alarm;
    logic        running;

    modport master (
        input  btn_set, btn_start, sw, sec_1, sec_10, min_1, min_10,
        output state, timer, alarm, running
    );

    modport slave (
        output btn_set, btn_start, sw, sec_1, sec_10, min_1, min_10,
        input  state, timer, alarm, running
    );
endinterface

// File: rtl/egg_timer_ctrl.sv
// Egg-timer sequencer: button edges -> datapath command codes, BCD preset,
// 1 Hz decrement strobe and blinking alarm on 00:00.
module egg_timer_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic             clkIn,
    input  logic             reset_btn,
    egg_timer_ctrl_if.master io
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SET_SEC = 3'd1;
    localparam logic [2:0] S_SET_MIN = 3'd2;
    localparam logic [2:0] S_ARMED   = 3'd3;
    localparam logic [2:0] S_COUNT   = 3'd4;
    localparam logic [2:0] S_PAUSE   = 3'd5;
    localparam logic [2:0] S_ALARM   = 3'd6;

    localparam logic [2:0] C_CLEAR    = 3'b000;
    localparam logic [2:0] C_LOAD_SEC = 3'b001;
    localparam logic [2:0] C_LOAD_MIN = 3'b010;
    localparam logic [2:0] C_ARMED    = 3'b011;
    localparam logic [2:0] C_HOLD     = 3'b100;
    localparam logic [2:0] C_DEC      = 3'b101;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [2:0]       fsm;
    logic             set_q, set_p, start_q, start_p;
    logic [CNT_W-1:0] presc;
    logic [2:0]       state_q;
    logic [15:0]      timer_q;
    logic             alarm_q, running_q;
    logic             set_edge, start_edge, tick, digits_zero;

    function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
        logic [3:0] tens, units;
        tens  = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
        units = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {tens, units};
    endfunction

    assign set_edge    = set_q & ~set_p;
    assign start_edge  = start_q & ~start_p;
    assign tick        = (presc == TICK_LAST);
    assign digits_zero = ({io.min_10, io.min_1, io.sec_10, io.sec_1} == 16'h0000);

    always_ff @(posedge clkIn) begin
        if (reset_btn) begin
            // prev copies reset high so a button held through reset is not an edge
            set_q     <= 1'b1;
            set_p     <= 1'b1;
            start_q   <= 1'b1;
            start_p   <= 1'b1;
            fsm       <= S_IDLE;
            state_q   <= C_CLEAR;
            timer_q   <= '0;
            alarm_q   <= 1'b0;
            running_q <= 1'b0;
            presc     <= '0;
        end else begin
            set_q   <= io.btn_set;
            set_p   <= set_q;
            start_q <= io.btn_start;
            start_p <= start_q;

            if (fsm == S_COUNT || fsm == S_ALARM)
                presc <= tick ? '0 : presc + 1'b1;

            case (fsm)
                S_IDLE: begin
                    timer_q <= '0;
                    if (set_edge) begin
                        fsm     <= S_SET_SEC;
                        state_q <= C_LOAD_SEC;
                    end
                end
                S_SET_SEC: if (set_edge) begin
                    timer_q[7:0] <= clamp_bcd(io.sw);
                    fsm          <= S_SET_MIN;
                    state_q      <= C_LOAD_MIN;
                end
                S_SET_MIN: if (set_edge) begin
                    timer_q[15:8] <= clamp_bcd(io.sw);
                    fsm           <= S_ARMED;
                    state_q       <= C_ARMED;
                end
                S_ARMED: begin
                    if (start_edge) begin
                        presc     <= '0;
                        fsm       <= S_COUNT;
                        state_q   <= C_HOLD;
                        running_q <= 1'b1;
                    end else if (set_edge) begin
                        fsm     <= S_SET_SEC;
                        state_q <= C_LOAD_SEC;
                    end
                end
                S_COUNT: begin
                    // zero check first so the datapath is never told to go below 00:00
                    if (digits_zero) begin
                        fsm       <= S_ALARM;
                        state_q   <= C_HOLD;
                        running_q <= 1'b0;
                        alarm_q   <= 1'b1;
                    end else if (start_edge) begin
                        fsm       <= S_PAUSE;
                        state_q   <= C_HOLD;
                        running_q <= 1'b0;
                    end else begin
                        state_q <= (tick && state_q != C_DEC) ? C_DEC : C_HOLD;
                    end
                end
                S_PAUSE: begin
                    if (start_edge) begin
                        presc     <= '0;
                        fsm       <= S_COUNT;
                        running_q <= 1'b1;
                    end else if (set_edge) begin
                        fsm     <= S_IDLE;
                        state_q <= C_CLEAR;
                        timer_q <= '0;
                    end
                end
                S_ALARM: begin
                    if (set_edge || start_edge) begin
                        fsm     <= S_IDLE;
                        state_q <= C_CLEAR;
                        timer_q <= '0;
                        alarm_q <= 1'b0;
                    end else if (tick) begin
                        alarm_q <= ~alarm_q;
                    end
                end
                default: begin
                    fsm       <= S_IDLE;
                    state_q   <= C_CLEAR;
                    timer_q   <= '0;
                    alarm_q   <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.state   = state_q;
    assign io.timer   = timer_q;
    assign io.alarm   = alarm_q;
    assign io.running = running_q;
endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: directed test-plan sequences plus random button
// traffic, every cycle compared against a seconds/minutes level reference model.
module tb_egg_timer_ctrl;
    localparam int TICK = 4;

    logic clkIn = 1'b0;
    logic reset_btn;
    egg_timer_ctrl_if bus();

    egg_timer_ctrl #(.TICK_DIV(TICK), .CNT_W(4)) dut (
        .clkIn    (clkIn),
        .reset_btn(reset_btn),
        .io       (bus)
    );

    always #5 clkIn = ~clkIn;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int clamp_val(input logic [7:0] v);
        int t, u;
        t = (int'(v[7:4]) > 5) ? 5 : int'(v[7:4]);
        u = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
        return t * 10 + u;
    endfunction

    // Datapath stand-in: remaining time held as a plain second count
    int dp_secs = 0;
    assign {bus.min_10, bus.min_1} = to_bcd(dp_secs / 60);
    assign {bus.sec_10, bus.sec_1} = to_bcd(dp_secs % 60);

    always @(posedge clkIn) begin
        case (bus.state)
            3'b000:                 dp_secs <= 0;
            3'b001, 3'b010, 3'b011: dp_secs <= bcd_val(bus.timer[15:8]) * 60 + bcd_val(bus.timer[7:0]);
            3'b101:                 if (dp_secs > 0) dp_secs <= dp_secs - 1;
            default: ;
        endcase
    end

    // Reference model
    typedef enum {M_IDLE, M_SETS, M_SETM, M_ARM, M_CNT, M_PAU, M_ALM} mode_t;
    mode_t    mode = M_IDLE;
    int       m_sec = 0, m_min = 0, ph = 0;
    bit       m_alarm = 0, m_pulse = 0;
    bit [1:0] set_hist = 2'b11, start_hist = 2'b11;
    bit       m_se, m_st, m_tk;

    always @(posedge clkIn) begin
        if (reset_btn) begin
            mode = M_IDLE; m_sec = 0; m_min = 0; ph = 0;
            m_alarm = 0; m_pulse = 0;
            set_hist = 2'b11; start_hist = 2'b11;
        end else begin
            m_se = set_hist[0] && !set_hist[1];
            m_st = start_hist[0] && !start_hist[1];
            set_hist   = {set_hist[0], bus.btn_set};
            start_hist = {start_hist[0], bus.btn_start};
            m_tk = ((ph % TICK) == TICK - 1);
            m_pulse = 0;
            if (mode == M_CNT || mode == M_ALM) ph = (ph + 1) % TICK;
            case (mode)
                M_IDLE: begin m_sec = 0; m_min = 0; if (m_se) mode = M_SETS; end
                M_SETS: if (m_se) begin m_sec = clamp_val(bus.sw); mode = M_SETM; end
                M_SETM: if (m_se) begin m_min = clamp_val(bus.sw); mode = M_ARM; end
                M_ARM:  if (m_st) begin ph = 0; mode = M_CNT; end
                        else if (m_se) mode = M_SETS;
                M_CNT:  if (dp_secs == 0) begin mode = M_ALM; m_alarm = 1; end
                        else if (m_st) mode = M_PAU;
                        else m_pulse = m_tk;
                M_PAU:  if (m_st) begin ph = 0; mode = M_CNT; end
                        else if (m_se) begin mode = M_IDLE; m_sec = 0; m_min = 0; end
                M_ALM:  if (m_se || m_st) begin mode = M_IDLE; m_alarm = 0; m_sec = 0; m_min = 0; end
                        else if (m_tk) m_alarm = !m_alarm;
                default: mode = M_IDLE;
            endcase
        end
    end

    logic [2:0] exp_state;
    always_comb begin
        exp_state = 3'b100;
        case (mode)
            M_IDLE: exp_state = 3'b000;
            M_SETS: exp_state = 3'b001;
            M_SETM: exp_state = 3'b010;
            M_ARM:  exp_state = 3'b011;
            M_CNT:  exp_state = m_pulse ? 3'b101 : 3'b100;
            default: exp_state = 3'b100;
        endcase
    end

    always @(negedge clkIn) if (chk_on) begin
        chk("model_state",   16'(bus.state),   16'(exp_state));
        chk("model_timer",   bus.timer,        {to_bcd(m_min), to_bcd(m_sec)});
        chk("model_alarm",   16'(bus.alarm),   16'(m_alarm));
        chk("model_running", 16'(bus.running), 16'(mode == M_CNT));
    end

    task automatic press(input bit use_start, input int hold);
        if (use_start) bus.btn_start = 1'b1; else bus.btn_set = 1'b1;
        repeat (hold) @(negedge clkIn);
        bus.btn_start = 1'b0;
        bus.btn_set   = 1'b0;
        repeat (2) @(negedge clkIn);
    endtask

    task automatic program_preset(input logic [7:0] s, input logic [7:0] m);
        bus.sw = s; press(0, 1);
        bus.sw = m; press(0, 1);
    endtask

    int n, pulses;

    initial begin
        bus.btn_set = 1'b0; bus.btn_start = 1'b0; bus.sw = 8'h00;
        reset_btn = 1'b1;
        repeat (3) @(negedge clkIn);
        chk("rst_state",   16'(bus.state),   16'h0);
        chk("rst_timer",   bus.timer,        16'h0);
        chk("rst_alarm",   16'(bus.alarm),   16'h0);
        chk("rst_running", 16'(bus.running), 16'h0);
        reset_btn = 1'b0;
        chk_on = 1'b1;
        @(negedge clkIn);

        // Setup sequence with two-cycle button latency
        bus.btn_set = 1'b1;
        @(negedge clkIn); chk("lat_before", 16'(bus.state), 16'h0);
        @(negedge clkIn); chk("lat_after",  16'(bus.state), 16'h1);
        bus.btn_set = 1'b0;
        repeat (2) @(negedge clkIn);
        bus.sw = 8'h30; press(0, 1); chk("set_min_state", 16'(bus.state), 16'h2);
        bus.sw = 8'h01; press(0, 1); chk("armed_state",   16'(bus.state), 16'h3);
        chk("preset_0130", bus.timer, 16'h0130);

        // Clamp, then re-edit to 00:02
        press(0, 1);
        bus.sw = 8'hFA; press(0, 1); chk("clamp_FA", 16'(bus.timer[7:0]), 16'h59);
        bus.sw = 8'h7C; press(0, 1); chk("clamp_7C", bus.timer, 16'h5959);
        press(0, 1);
        program_preset(8'h02, 8'h00);
        chk("preset_0002", bus.timer, 16'h0002);

        // Countdown to alarm
        press(1, 1);
        chk("running", 16'(bus.running), 16'h1);
        n = 0; pulses = 0;
        while (!bus.alarm && n < 60) begin
            @(negedge clkIn); n++;
            if (bus.state == 3'b101) pulses++;
        end
        chk("alarm_reached", 16'(bus.alarm), 16'h1);
        chk("dec_pulses_2",  16'(pulses),    16'd2);
        chk("alarm_code",    16'(bus.state), 16'h4);
        repeat (9) @(negedge clkIn);
        press(0, 1);
        chk("abort_state", 16'(bus.state), 16'h0);
        chk("abort_alarm", 16'(bus.alarm), 16'h0);
        chk("abort_timer", bus.timer,      16'h0);

        // Pause exactly on a tick cycle, then restart
        press(0, 1);
        program_preset(8'h05, 8'h00);
        press(1, 1);
        n = 0;
        while (bus.state != 3'b101 && n < 12) begin @(negedge clkIn); n++; end
        chk("first_pulse_seen", 16'(bus.state), 16'h5);
        repeat (2) @(negedge clkIn);
        bus.btn_start = 1'b1;
        repeat (2) @(negedge clkIn);
        chk("pause_code",    16'(bus.state),   16'h4);
        chk("pause_running", 16'(bus.running), 16'h0);
        bus.btn_start = 1'b0;
        pulses = 0;
        repeat (12) begin @(negedge clkIn); if (bus.state == 3'b101) pulses++; end
        chk("pause_no_pulse", 16'(pulses), 16'd0);
        chk("pause_digits",   16'(dp_secs), 16'd4);
        bus.btn_start = 1'b1; @(negedge clkIn); bus.btn_start = 1'b0;
        n = 0;
        while (!bus.running && n < 6) begin @(negedge clkIn); n++; end
        chk("resume_running", 16'(bus.running), 16'h1);
        n = 0;
        while (bus.state != 3'b101 && n < 20) begin @(negedge clkIn); n++; end
        chk("resume_gap", 16'(n), 16'd4);
        press(0, 2);
        chk("set_ignored", 16'(bus.running), 16'h1);
        n = 0;
        while (!bus.alarm && n < 100) begin @(negedge clkIn); n++; end
        chk("alarm2", 16'(bus.alarm), 16'h1);
        press(1, 1);
        chk("abort2_state", 16'(bus.state), 16'h0);

        // Set held through reset is not an edge
        bus.btn_set = 1'b1; reset_btn = 1'b1;
        repeat (2) @(negedge clkIn);
        reset_btn = 1'b0;
        repeat (3) @(negedge clkIn);
        chk("held_set_idle", 16'(bus.state), 16'h0);
        bus.btn_set = 1'b0;
        repeat (3) @(negedge clkIn);
        chk("held_release_idle", 16'(bus.state), 16'h0);

        // Preset 00:00 goes straight to alarm
        press(0, 1);
        program_preset(8'h00, 8'h00);
        press(1, 1);
        n = 0; pulses = 0;
        while (!bus.alarm && n < 20) begin
            if (bus.state == 3'b101) pulses++;
            @(negedge clkIn); n++;
        end
        chk("zero_alarm",  16'(bus.alarm), 16'h1);
        chk("zero_pulses", 16'(pulses),    16'd0);

        // Reset in COUNT
        press(0, 1);
        press(0, 1);
        program_preset(8'h09, 8'h00);
        press(1, 1);
        repeat (3) @(negedge clkIn);
        chk("pre_rst_running", 16'(bus.running), 16'h1);
        reset_btn = 1'b1;
        @(negedge clkIn);
        chk("mid_rst_state",   16'(bus.state),   16'h0);
        chk("mid_rst_timer",   bus.timer,        16'h0);
        chk("mid_rst_alarm",   16'(bus.alarm),   16'h0);
        chk("mid_rst_running", 16'(bus.running), 16'h0);
        reset_btn = 1'b0;
        @(negedge clkIn);

        // Random button traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) != 0) bus.sw = 8'($urandom_range(0, 3));
            else bus.sw = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: repeat ($urandom_range(1, 6)) @(negedge clkIn);
                3, 4, 5: press(0, $urandom_range(1, 3));
                6, 7, 8: press(1, $urandom_range(1, 3));
                default: if ($urandom_range(0, 4) == 0) begin
                    reset_btn = 1'b1; @(negedge clkIn); reset_btn = 1'b0;
                end else begin
                    @(negedge clkIn);
                end
            endcase
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
